ofs_fim_pwrgood_rst_seq: RTL and testbench
==========================================

Name: ofs_fim_pwrgood_rst_seq

Overview:
Parametrised power-good reset sequencer that consumes the board pwr_good_n level and produces NUM_CH staged, active-low channel resets.
- Synchronises and glitch-filters pwr_good_n.
- Releases channel resets in ascending order with a fixed inter-stage delay.
- Re-asserts all channel resets immediately on power loss or software restart.
- Sits at the top of the FIM reset tree, ahead of the per-subsystem reset bridges.

Parameters:
NUM_CH, 4, number of sequenced reset outputs (>=1)
SYNC_STAGES, 2, synchroniser flops on pwr_good_n (>=2)
FILTER_CYCLES, 16, consecutive synced-good cycles required before sequencing (>=1)
STAGE_DELAY, 8, cycles between successive channel releases (>=1)

Ports:
clk  input  1  sequencer clock
rst_n  input  1  synchronous active-low reset
pwr_good_n  input  1  asynchronous power-good, 0 = power good
seq_restart  input  1  single-cycle pulse; forces full re-sequence
ch_rst_n  output  NUM_CH  per-channel active-low resets
seq_done  output  1  all channels released
seq_state  output  2  FSM state: 0 HOLD, 1 FILTER, 2 RELEASE, 3 RUN
pg_drop_cnt  output  8  saturating power-loss event count

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is synchronous and active-low.
- State on rst_n=0: ch_rst_n=0, seq_done=0, seq_state=HOLD, counters=0, stage index=0, pg_drop_cnt=0. Every synchroniser flop is set to 1 (power not good).
- pg_sync: the last synchroniser stage. It has SYNC_STAGES cycles of latency.
- HOLD:
  - All ch_rst_n=0.
  - pg_sync==0 → FILTER with cnt=0.
- FILTER:
  - pg_sync==1 → HOLD.
  - Otherwise, if cnt==FILTER_CYCLES-1 → RELEASE with cnt=0 and idx=0.
  - Otherwise cnt++.
- RELEASE:
  - When cnt==STAGE_DELAY-1: ch_rst_n[idx]<=1, cnt=0, idx++.
  - If idx==NUM_CH-1 on that edge: go to RUN and set seq_done<=1 on the same edge.
  - Otherwise cnt++.
  - Channels already released stay high.
- RUN: holds all ch_rst_n=1 and seq_done=1.
- Release timing: with edge 1 defined as the first edge sampling pwr_good_n=0, channel k deasserts on edge SYNC_STAGES+1+FILTER_CYCLES+STAGE_DELAY*(k+1).
- Power loss: pg_sync==1 in FILTER, RELEASE or RUN gives, on the next edge:
  - all ch_rst_n=0, seq_done=0;
  - state HOLD, counters cleared.
  - Latency from the pwr_good_n rising edge is SYNC_STAGES+1 edges.
- seq_restart:
  - In RELEASE or RUN it has the same effect as a power loss.
  - It is ignored in HOLD and FILTER.
- Priority: power loss beats seq_restart. Both on the same edge count as one power-loss event.
- pg_drop_cnt:
  - +1 on each power-loss exit from RELEASE or RUN.
  - Not incremented for FILTER aborts or seq_restart.
  - Saturates at 8'hFF, no wrap.
- Glitches: any single synced-high cycle in FILTER restarts the filter from HOLD. The counter never accumulates across glitches.
- rst_n asserted mid-sequence: on the next edge all outputs take their reset values. pg_drop_cnt is cleared.
- All outputs are registered. There are no combinational input-to-output paths.

Optional Feature:
Macro OFS_FIM_PWRGOOD_DROP_CNT_EN.
- Defined: pg_drop_cnt is implemented as described in Behaviour.
- Undefined: the counter logic is removed and pg_drop_cnt is tied to 8'h00. All other behaviour is identical.

Test Plan:
- Nominal sequence. Config: NUM_CH=2, SYNC_STAGES=2, FILTER_CYCLES=4, STAGE_DELAY=2. Drive pwr_good_n=0 before edge 1. Expect:
  - ch_rst_n[0]=1 after edge 9;
  - ch_rst_n[1]=1 and seq_done=1 after edge 11;
  - seq_state goes 0→1 (edge 3), 2 (edge 7), 3 (edge 11).
- Glitch filtering. Same config. Hold pwr_good_n low for 3 cycles, pulse it high for 1 cycle, then hold it low. Expect:
  - FILTER returns to HOLD and all ch_rst_n stay 0;
  - sequencing restarts, with ch_rst_n[0] release measured from the second falling edge;
  - pg_drop_cnt stays 0.
- Power loss in RUN. Raise pwr_good_n. Expect within 3 edges: all ch_rst_n=0, seq_done=0, seq_state=0, pg_drop_cnt=1.
- Drop mid-RELEASE plus simultaneous restart. Raise pwr_good_n after ch0 is released and pulse seq_restart on the same edge the synced drop arrives. Expect all resets asserted, pg_drop_cnt incremented by exactly 1, and ch1 never released.
- Restart and saturation:
  - seq_restart in RUN → full re-sequence with unchanged pg_drop_cnt.
  - 260 power-loss events → pg_drop_cnt=8'hFF.
  - With OFS_FIM_PWRGOOD_DROP_CNT_EN undefined → pg_drop_cnt=0 throughout.
- Synchronous reset mid-sequence. Assert rst_n=0 during RELEASE with ch0 released. Expect all ch_rst_n=0, seq_state=0 and pg_drop_cnt=0 after the next edge. Expect a full clean sequence after rst_n returns to 1.

Source files
------------

// File: rtl/ofs_fim_pwrgood_rst_seq.sv
// rtl/ofs_fim_pwrgood_rst_seq.sv - power-good reset sequencer with staged channel releases (option: OFS_FIM_PWRGOOD_DROP_CNT_EN)
module ofs_fim_pwrgood_rst_seq #(
    parameter int NUM_CH        = 4,
    parameter int SYNC_STAGES   = 2,
    parameter int FILTER_CYCLES = 16,
    parameter int STAGE_DELAY   = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              pwr_good_n,
    input  logic              seq_restart,
    output logic [NUM_CH-1:0] ch_rst_n,
    output logic              seq_done,
    output logic [1:0]        seq_state,
    output logic [7:0]        pg_drop_cnt
);

    localparam int CNT_MAX = (FILTER_CYCLES > STAGE_DELAY) ? FILTER_CYCLES : STAGE_DELAY;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    typedef enum logic [1:0] {
        S_HOLD    = 2'd0,
        S_FILTER  = 2'd1,
        S_RELEASE = 2'd2,
        S_RUN     = 2'd3
    } state_t;

    state_t                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [IDX_W-1:0]       idx_q;
    logic [NUM_CH-1:0]      ch_rst_q;
    logic                   done_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   pg_sync;
    logic                   active;

    assign pg_sync = sync_q[SYNC_STAGES-1];
    // Channels are (being) released only in RELEASE and RUN; only there do drops count.
    assign active  = (state_q == S_RELEASE) || (state_q == S_RUN);

    // Synchroniser for pwr_good_n; resets to "power not good".
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwr_good_n};
        end
    end

    // Sequencer FSM: filter good power, then release channels one stage apart.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_HOLD;
            cnt_q    <= '0;
            idx_q    <= '0;
            ch_rst_q <= '0;
            done_q   <= 1'b0;
        end else begin
            case (state_q)
                S_HOLD: begin
                    ch_rst_q <= '0;
                    done_q   <= 1'b0;
                    cnt_q    <= '0;
                    idx_q    <= '0;
                    if (!pg_sync) begin
                        state_q <= S_FILTER;
                    end
                end
                S_FILTER: begin
                    if (pg_sync) begin
                        // A single bad cycle discards all accumulated filter time.
                        state_q <= S_HOLD;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_W'(FILTER_CYCLES - 1)) begin
                        state_q <= S_RELEASE;
                        cnt_q   <= '0;
                        idx_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_RELEASE: begin
                    if (pg_sync || seq_restart) begin
                        state_q  <= S_HOLD;
                        cnt_q    <= '0;
                        idx_q    <= '0;
                        ch_rst_q <= '0;
                        done_q   <= 1'b0;
                    end else if (cnt_q == CNT_W'(STAGE_DELAY - 1)) begin
                        ch_rst_q[idx_q] <= 1'b1;
                        cnt_q           <= '0;
                        if (idx_q == IDX_W'(NUM_CH - 1)) begin
                            state_q <= S_RUN;
                            done_q  <= 1'b1;
                            idx_q   <= '0;
                        end else begin
                            idx_q <= idx_q + 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: begin
                    if (pg_sync || seq_restart) begin
                        state_q  <= S_HOLD;
                        cnt_q    <= '0;
                        idx_q    <= '0;
                        ch_rst_q <= '0;
                        done_q   <= 1'b0;
                    end else begin
                        ch_rst_q <= '1;
                        done_q   <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign ch_rst_n  = ch_rst_q;
    assign seq_done  = done_q;
    assign seq_state = state_q;

`ifdef OFS_FIM_PWRGOOD_DROP_CNT_EN
    logic [7:0] drop_q;

    // Count power-loss exits from RELEASE/RUN, saturating at 8'hFF.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            drop_q <= 8'h00;
        end else if (active && pg_sync && (drop_q != 8'hFF)) begin
            drop_q <= drop_q + 8'd1;
        end
    end

    assign pg_drop_cnt = drop_q;
`else
    logic unused_active;
    assign unused_active = active;
    assign pg_drop_cnt   = 8'h00;
`endif

endmodule

// File: tb/tb_ofs_fim_pwrgood_rst_seq.sv
// tb/tb_ofs_fim_pwrgood_rst_seq.sv - directed self-checking bench for ofs_fim_pwrgood_rst_seq
module tb_ofs_fim_pwrgood_rst_seq;

`ifdef OFS_FIM_PWRGOOD_DROP_CNT_EN
    localparam bit DROP_EN = 1'b1;
`else
    localparam bit DROP_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       pwr_good_n;
    logic       seq_restart;
    logic [1:0] ch_rst_n;
    logic       seq_done;
    logic [1:0] seq_state;
    logic [7:0] pg_drop_cnt;

    int total = 0;
    int bad   = 0;
    logic [7:0] exp_drop = 8'h00;

    ofs_fim_pwrgood_rst_seq #(
        .NUM_CH        (2),
        .SYNC_STAGES   (2),
        .FILTER_CYCLES (4),
        .STAGE_DELAY   (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pwr_good_n  (pwr_good_n),
        .seq_restart (seq_restart),
        .ch_rst_n    (ch_rst_n),
        .seq_done    (seq_done),
        .seq_state   (seq_state),
        .pg_drop_cnt (pg_drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bump_drop();
        if (DROP_EN && exp_drop != 8'hFF) exp_drop = exp_drop + 8'd1;
    endtask

    // FILTER entered on edge f: RELEASE f+4, ch0 f+6, ch1 and RUN f+8.
    task automatic seq_run(input int f, input int n, input string tag);
        logic [1:0] est;
        logic [1:0] ech;
        logic       edone;
        for (int e = 1; e <= n; e++) begin
            tick();
            est   = (e < f) ? 2'd0 : (e < f + 4) ? 2'd1 : (e < f + 8) ? 2'd2 : 2'd3;
            ech   = {(e >= f + 8), (e >= f + 6)};
            edone = (e >= f + 8);
            total++;
            if (seq_state !== est || ch_rst_n !== ech || seq_done !== edone) begin
                bad++;
                $display("FAIL %s edge %0d: state=%0d ch=%b done=%b expected state=%0d ch=%b done=%b",
                         tag, e, seq_state, ch_rst_n, seq_done, est, ech, edone);
            end
            total++;
            if (pg_drop_cnt !== exp_drop) begin
                bad++;
                $display("FAIL %s_drop edge %0d: got %0d expected %0d", tag, e, pg_drop_cnt, exp_drop);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; pwr_good_n = 1'b1; seq_restart = 1'b0;
        tick(); tick();
        total++;
        if (ch_rst_n !== 2'b00 || seq_done !== 1'b0 || seq_state !== 2'd0 || pg_drop_cnt !== 8'h00) begin
            bad++;
            $display("FAIL reset: ch=%b done=%b state=%0d drop=%0d expected ch=00 done=0 state=0 drop=0",
                     ch_rst_n, seq_done, seq_state, pg_drop_cnt);
        end
        rst_n = 1'b1;
        tick(); tick();
        total++;
        if (seq_state !== 2'd0 || ch_rst_n !== 2'b00) begin
            bad++;
            $display("FAIL reset_hold: state=%0d ch=%b expected state=0 ch=00", seq_state, ch_rst_n);
        end
    endtask

    task automatic test_nominal();
        pwr_good_n = 1'b0;
        seq_run(3, 12, "nominal");
    endtask

    task automatic test_power_loss_run();
        pwr_good_n = 1'b1;
        for (int e = 1; e <= 3; e++) begin
            tick();
            if (e == 3) bump_drop();
            total++;
            if (e < 3) begin
                if (seq_state !== 2'd3 || ch_rst_n !== 2'b11 || seq_done !== 1'b1) begin
                    bad++;
                    $display("FAIL loss_run edge %0d: state=%0d ch=%b done=%b expected state=3 ch=11 done=1",
                             e, seq_state, ch_rst_n, seq_done);
                end
            end else begin
                if (seq_state !== 2'd0 || ch_rst_n !== 2'b00 || seq_done !== 1'b0 || pg_drop_cnt !== exp_drop) begin
                    bad++;
                    $display("FAIL loss_run edge 3: state=%0d ch=%b done=%b drop=%0d expected state=0 ch=00 done=0 drop=%0d",
                             seq_state, ch_rst_n, seq_done, pg_drop_cnt, exp_drop);
                end
            end
        end
    endtask

    task automatic test_glitch();
        logic [1:0] est;
        logic [1:0] ech;
        // Glitch high sampled on edge 4; second falling edge is edge 5, FILTER re-entered on 7.
        for (int e = 1; e <= 16; e++) begin
            pwr_good_n = (e == 4);
            tick();
            if (e <= 2)      est = 2'd0;
            else if (e <= 5) est = 2'd1;
            else if (e == 6) est = 2'd0;
            else if (e < 11) est = 2'd1;
            else if (e < 15) est = 2'd2;
            else             est = 2'd3;
            ech = {(e >= 15), (e >= 13)};
            total++;
            if (seq_state !== est || ch_rst_n !== ech || seq_done !== (e >= 15) || pg_drop_cnt !== exp_drop) begin
                bad++;
                $display("FAIL glitch edge %0d: state=%0d ch=%b done=%b drop=%0d expected state=%0d ch=%b done=%b drop=%0d",
                         e, seq_state, ch_rst_n, seq_done, pg_drop_cnt, est, ech, (e >= 15), exp_drop);
            end
        end
    endtask

    task automatic test_restart_run();
        seq_restart = 1'b1;
        tick();
        seq_restart = 1'b0;
        total++;
        if (seq_state !== 2'd0 || ch_rst_n !== 2'b00 || seq_done !== 1'b0 || pg_drop_cnt !== exp_drop) begin
            bad++;
            $display("FAIL restart_run: state=%0d ch=%b done=%b drop=%0d expected state=0 ch=00 done=0 drop=%0d",
                     seq_state, ch_rst_n, seq_done, pg_drop_cnt, exp_drop);
        end
        seq_run(1, 10, "restart_reseq");
    endtask

    task automatic test_drop_restart();
        logic [1:0] est;
        logic [1:0] ech;
        seq_restart = 1'b1;
        tick();
        seq_restart = 1'b0;
        // ch0 releases on edge 7; synced drop and restart both hit on edge 9, when ch1 would release.
        for (int e = 1; e <= 12; e++) begin
            pwr_good_n  = (e >= 7);
            seq_restart = (e == 9);
            tick();
            if (e == 9) bump_drop();
            est = (e < 5) ? 2'd1 : (e < 9) ? 2'd2 : 2'd0;
            ech = (e == 7 || e == 8) ? 2'b01 : 2'b00;
            total++;
            if (seq_state !== est || ch_rst_n !== ech || seq_done !== 1'b0 || pg_drop_cnt !== exp_drop) begin
                bad++;
                $display("FAIL drop_restart edge %0d: state=%0d ch=%b done=%b drop=%0d expected state=%0d ch=%b done=0 drop=%0d",
                         e, seq_state, ch_rst_n, seq_done, pg_drop_cnt, est, ech, exp_drop);
            end
        end
        seq_restart = 1'b0;
    endtask

    task automatic test_sync_reset();
        pwr_good_n = 1'b0;
        seq_run(3, 9, "pre_reset");
        rst_n = 1'b0;
        tick();
        exp_drop = 8'h00;
        total++;
        if (seq_state !== 2'd0 || ch_rst_n !== 2'b00 || seq_done !== 1'b0 || pg_drop_cnt !== 8'h00) begin
            bad++;
            $display("FAIL sync_reset: state=%0d ch=%b done=%b drop=%0d expected state=0 ch=00 done=0 drop=0",
                     seq_state, ch_rst_n, seq_done, pg_drop_cnt);
        end
        rst_n = 1'b1;
        seq_run(3, 12, "post_reset");
    endtask

    task automatic test_saturation();
        for (int i = 0; i < 260; i++) begin
            pwr_good_n = 1'b1;
            tick(); tick(); tick();
            bump_drop();
            total++;
            if (seq_state !== 2'd0 || pg_drop_cnt !== exp_drop) begin
                bad++;
                $display("FAIL saturation event %0d: state=%0d drop=%0d expected state=0 drop=%0d",
                         i, seq_state, pg_drop_cnt, exp_drop);
            end
            pwr_good_n = 1'b0;
            for (int k = 0; k < 11; k++) tick();
        end
        total++;
        if (pg_drop_cnt !== (DROP_EN ? 8'hFF : 8'h00) || seq_state !== 2'd3) begin
            bad++;
            $display("FAIL saturation_final: drop=%0d state=%0d expected drop=%0d state=3",
                     pg_drop_cnt, seq_state, (DROP_EN ? 8'hFF : 8'h00));
        end
    endtask

    initial begin
        rst_n = 1'b0; pwr_good_n = 1'b1; seq_restart = 1'b0;
        test_reset();
        test_nominal();
        test_power_loss_run();
        test_glitch();
        test_restart_run();
        test_drop_restart();
        test_sync_reset();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
